// File: rtl/prim_onehot_arb_pkg.sv
// Shared types for the round-robin onehot arbiter.
// State encodings sit at Hamming distance 2 so a single upset lands on an invalid code.
package prim_onehot_arb_pkg;

    typedef enum logic [2:0] {
        ArbIdle  = 3'b000,
        ArbGrant = 3'b011
    } arb_state_e;

endpackage

// File: rtl/prim_onehot_arb_if.sv
// Request/grant bundle between requesters and the arbiter.
// The master modport is the arbiter side; slave is the requester/consumer side.
interface prim_onehot_arb_if #(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned NumReq    = 2**AddrWidth
);
    logic [NumReq-1:0]    req_i;
    logic                 lock_i;
    logic                 ready_i;
    logic                 valid_o;
    logic [NumReq-1:0]    oh_o;
    logic [AddrWidth-1:0] idx_o;
    logic [NumReq-1:0]    gnt_o;

    modport master (
        input  req_i, lock_i, ready_i,
        output valid_o, oh_o, idx_o, gnt_o
    );

    modport slave (
        output req_i, lock_i, ready_i,
        input  valid_o, oh_o, idx_o, gnt_o
    );
endinterface

// File: rtl/prim_onehot_arb_pick.sv
// Combinational fixed-priority picker: lowest index set in req & mask wins.
module prim_onehot_arb_pick #(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned NumReq    = 2**AddrWidth
) (
    input  logic [NumReq-1:0]    req,
    input  logic [NumReq-1:0]    mask,
    output logic [NumReq-1:0]    oh,
    output logic [AddrWidth-1:0] idx,
    output logic                 any
);
    always_comb begin
        oh  = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (req[i] && mask[i] && !any) begin
                any    = 1'b1;
                oh[i]  = 1'b1;
                idx    = AddrWidth'(i);
            end
        end
    end
endmodule

// File: rtl/prim_onehot_arb.sv
// Round-robin arbiter with registered onehot grant, binary index and valid.
// Optional multi-beat lock via `define PRIM_ONEHOT_ARB_LOCK_EN.
module prim_onehot_arb
    import prim_onehot_arb_pkg::*;
#(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned NumReq    = 2**AddrWidth
) (
    input logic               clk_i,
    input logic               rst_ni,
    prim_onehot_arb_if.master bus
);
    arb_state_e           state_q;
    logic                 valid_q;
    logic [NumReq-1:0]    oh_q;
    logic [AddrWidth-1:0] idx_q;
    logic [AddrWidth-1:0] last_q;

    logic [AddrWidth-1:0] ptr;
    logic [NumReq-1:0]    mask;
    logic [NumReq-1:0]    all_ones;
    logic [NumReq-1:0]    hi_oh, lo_oh, pick_oh;
    logic [AddrWidth-1:0] hi_idx, lo_idx, pick_idx;
    logic                 hi_any, lo_any;
    logic                 lock_hold;

    // While a grant is up, the next pick must already treat the current winner
    // as the last one served, since last_q only catches up on the accept edge.
    assign ptr      = (state_q == ArbGrant) ? idx_q : last_q;
    assign all_ones = '1;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            mask[i] = (AddrWidth'(i) > ptr);
        end
    end

    prim_onehot_arb_pick #(
        .AddrWidth(AddrWidth),
        .NumReq   (NumReq)
    ) u_pick_hi (
        .req (bus.req_i),
        .mask(mask),
        .oh  (hi_oh),
        .idx (hi_idx),
        .any (hi_any)
    );

    prim_onehot_arb_pick #(
        .AddrWidth(AddrWidth),
        .NumReq   (NumReq)
    ) u_pick_lo (
        .req (bus.req_i),
        .mask(all_ones),
        .oh  (lo_oh),
        .idx (lo_idx),
        .any (lo_any)
    );

    assign pick_oh  = hi_any ? hi_oh  : lo_oh;
    assign pick_idx = hi_any ? hi_idx : lo_idx;

`ifdef PRIM_ONEHOT_ARB_LOCK_EN
    assign lock_hold = bus.lock_i & bus.req_i[idx_q];
`else
    logic unused_lock;
    assign unused_lock = bus.lock_i;
    assign lock_hold   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ArbIdle;
            valid_q <= 1'b0;
            oh_q    <= '0;
            idx_q   <= '0;
            last_q  <= AddrWidth'(NumReq - 1);
        end else begin
            case (state_q)
                ArbIdle: begin
                    if (lo_any) begin
                        state_q <= ArbGrant;
                        valid_q <= 1'b1;
                        oh_q    <= pick_oh;
                        idx_q   <= pick_idx;
                    end
                end
                ArbGrant: begin
                    if (bus.ready_i && !lock_hold) begin
                        last_q <= idx_q;
                        if (lo_any) begin
                            oh_q  <= pick_oh;
                            idx_q <= pick_idx;
                        end else begin
                            state_q <= ArbIdle;
                            valid_q <= 1'b0;
                            oh_q    <= '0;
                            idx_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ArbIdle;
                    valid_q <= 1'b0;
                    oh_q    <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.oh_o    = oh_q;
    assign bus.idx_o   = idx_q;
    assign bus.gnt_o   = oh_q & {NumReq{valid_q & bus.ready_i}};

endmodule

// File: tb/tb_prim_onehot_arb.sv
// Self-checking bench for prim_onehot_arb (32-requester and 5-requester instances).
module tb_prim_onehot_arb;

`ifdef PRIM_ONEHOT_ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prim_onehot_arb_if #(.AddrWidth(5), .NumReq(32)) bus32 ();
    prim_onehot_arb_if #(.AddrWidth(3), .NumReq(5))  bus5 ();

    prim_onehot_arb #(.AddrWidth(5), .NumReq(32)) dut32 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus32.master)
    );

    prim_onehot_arb #(.AddrWidth(3), .NumReq(5)) dut5 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus5.master)
    );

    int checks = 0;
    int passed = 0;

    logic [31:0] cur_req32;
    logic [4:0]  cur_req5;
    logic        cur_ready;
    logic        cur_lock;

    // Reference model: index 0 = 32-requester DUT, index 1 = 5-requester DUT.
    bit m_valid [2];
    int m_idx   [2];
    int m_last  [2];
    int nreq    [2] = '{32, 5};

    function automatic int rr_pick(input logic [31:0] r, input int last, input int n);
        for (int k = 1; k <= n; k++) begin
            int j;
            j = (last + k) % n;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_oh(input int k);
        return m_valid[k] ? (32'h1 << m_idx[k]) : 32'h0;
    endfunction

    function automatic int exp_idx(input int k);
        return m_valid[k] ? m_idx[k] : 0;
    endfunction

    function automatic logic [31:0] exp_gnt(input int k);
        return (m_valid[k] && cur_ready) ? exp_oh(k) : 32'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_idx[k]   = 0;
            m_last[k]  = nreq[k] - 1;
        end
    endtask

    task automatic model_step(input int k, input logic [31:0] r);
        if (!m_valid[k]) begin
            if (r != 0) begin
                m_valid[k] = 1'b1;
                m_idx[k]   = rr_pick(r, m_last[k], nreq[k]);
            end
        end else if (cur_ready) begin
            if (!(LockEn && cur_lock && r[m_idx[k]])) begin
                m_last[k] = m_idx[k];
                if (r != 0) m_idx[k] = rr_pick(r, m_idx[k], nreq[k]);
                else        m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic apply_in(input logic [31:0] r32, input logic [4:0] r5,
                            input logic rdy, input logic lk);
        cur_req32     = r32;
        cur_req5      = r5;
        cur_ready     = rdy;
        cur_lock      = lk;
        bus32.req_i   = r32;
        bus32.ready_i = rdy;
        bus32.lock_i  = lk;
        bus5.req_i    = r5;
        bus5.ready_i  = rdy;
        bus5.lock_i   = lk;
    endtask

    task automatic advance();
        model_step(0, cur_req32);
        model_step(1, {27'b0, cur_req5});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply_in('0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_in('0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (bus32.valid_o !== 1'b0) $display("FAIL reset_valid32: got %b want 0", bus32.valid_o); else passed++;
        checks++; if (bus32.oh_o !== 32'h0) $display("FAIL reset_oh32: got %h want 0", bus32.oh_o); else passed++;
        checks++; if (bus32.idx_o !== 5'd0) $display("FAIL reset_idx32: got %0d want 0", bus32.idx_o); else passed++;
        checks++; if (bus5.valid_o !== 1'b0 || bus5.oh_o !== 5'h0 || bus5.idx_o !== 3'd0)
            $display("FAIL reset_out5: got v=%b oh=%h idx=%0d want 0/0/0", bus5.valid_o, bus5.oh_o, bus5.idx_o);
        else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_in(32'h8000_0001, 5'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus32.valid_o !== 1'b0) $display("FAIL first_req_latency: got valid %b want 0", bus32.valid_o); else passed++;
        advance();
        @(negedge clk);
        checks++; if (bus32.valid_o !== 1'b1) $display("FAIL first_valid: got %b want 1", bus32.valid_o); else passed++;
        checks++; if (bus32.oh_o !== 32'h1) $display("FAIL first_oh: got %h want 00000001", bus32.oh_o); else passed++;
        checks++; if (bus32.idx_o !== 5'd0) $display("FAIL first_idx: got %0d want 0", bus32.idx_o); else passed++;
        checks++; if (bus32.gnt_o !== 32'h1) $display("FAIL first_gnt: got %h want 00000001", bus32.gnt_o); else passed++;
        advance();
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        do_reset();
        apply_in(32'hF, 5'h0, 1'b1, 1'b0);
        @(negedge clk);
        advance();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus32.idx_o !== 5'(seq[i])) $display("FAIL rr_idx[%0d]: got %0d want %0d", i, bus32.idx_o, seq[i]); else passed++;
            checks++; if (bus32.gnt_o !== (32'h1 << seq[i])) $display("FAIL rr_gnt[%0d]: got %h want %h", i, bus32.gnt_o, 32'h1 << seq[i]); else passed++;
            advance();
        end
    endtask

    task automatic test_stall();
        do_reset();
        apply_in(32'h4, 5'h0, 1'b0, 1'b0);
        @(negedge clk);
        advance();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus32.oh_o !== 32'h4 || bus32.idx_o !== 5'd2 || bus32.gnt_o !== 32'h0)
                $display("FAIL stall_hold[%0d]: got oh=%h idx=%0d gnt=%h want 00000004/2/0", i, bus32.oh_o, bus32.idx_o, bus32.gnt_o);
            else passed++;
            advance();
        end
        apply_in(32'h0, 5'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus32.valid_o !== 1'b1 || bus32.idx_o !== 5'd2)
                $display("FAIL sticky_grant[%0d]: got v=%b idx=%0d want 1/2", i, bus32.valid_o, bus32.idx_o);
            else passed++;
            advance();
        end
        apply_in(32'h0, 5'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus32.gnt_o !== 32'h4) $display("FAIL stall_accept_gnt: got %h want 00000004", bus32.gnt_o); else passed++;
        advance();
        @(negedge clk);
        checks++; if (bus32.valid_o !== 1'b0 || bus32.oh_o !== 32'h0 || bus32.idx_o !== 5'd0 || bus32.gnt_o !== 32'h0)
            $display("FAIL stall_to_idle: got v=%b oh=%h idx=%0d gnt=%h want all 0", bus32.valid_o, bus32.oh_o, bus32.idx_o, bus32.gnt_o);
        else passed++;
        advance();
    endtask

    task automatic test_non_pow2();
        int seq [3] = '{0, 4, 0};
        do_reset();
        apply_in(32'h0, 5'h11, 1'b1, 1'b0);
        @(negedge clk);
        advance();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus5.idx_o !== 3'(seq[i])) $display("FAIL np2_idx[%0d]: got %0d want %0d", i, bus5.idx_o, seq[i]); else passed++;
            checks++; if (bus5.oh_o[bus5.idx_o] !== 1'b1 || !$onehot0(bus5.oh_o))
                $display("FAIL np2_onehot[%0d]: got oh=%h idx=%0d want onehot at idx", i, bus5.oh_o, bus5.idx_o);
            else passed++;
            advance();
        end
    endtask

    task automatic test_lock();
        do_reset();
        apply_in(32'h3, 5'h0, 1'b0, 1'b0);
        @(negedge clk);
        advance();
        apply_in(32'h3, 5'h0, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (bus32.idx_o !== 5'd0) $display("FAIL lock_first: got %0d want 0", bus32.idx_o); else passed++;
        advance();
        apply_in(32'h3, 5'h0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus32.idx_o !== (LockEn ? 5'd0 : 5'd1))
            $display("FAIL lock_second: got %0d want %0d", bus32.idx_o, LockEn ? 0 : 1);
        else passed++;
        advance();
        @(negedge clk);
        checks++; if (bus32.idx_o !== (LockEn ? 5'd1 : 5'd0))
            $display("FAIL lock_third: got %0d want %0d", bus32.idx_o, LockEn ? 1 : 0);
        else passed++;
        advance();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        apply_in(32'h4, 5'h4, 1'b0, 1'b0);
        @(negedge clk);
        advance();
        @(negedge clk);
        checks++; if (bus32.valid_o !== 1'b1 || bus32.idx_o !== 5'd2)
            $display("FAIL mid_pre: got v=%b idx=%0d want 1/2", bus32.valid_o, bus32.idx_o);
        else passed++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus32.valid_o !== 1'b0 || bus32.oh_o !== 32'h0 || bus32.idx_o !== 5'd0)
            $display("FAIL mid_async_clear: got v=%b oh=%h idx=%0d want 0/0/0", bus32.valid_o, bus32.oh_o, bus32.idx_o);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_in(32'h2, 5'h0, 1'b1, 1'b0);
        @(negedge clk);
        advance();
        @(negedge clk);
        checks++; if (bus32.valid_o !== 1'b1 || bus32.idx_o !== 5'd1)
            $display("FAIL mid_regrant: got v=%b idx=%0d want 1/1", bus32.valid_o, bus32.idx_o);
        else passed++;
        advance();
    endtask

    task automatic test_random();
        logic [31:0] r32;
        logic [4:0]  r5;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       r32 = 32'h0;
                1:       r32 = m_valid[0] ? (32'h1 << m_idx[0]) : (32'h1 << $urandom_range(0, 31));
                default: r32 = $urandom & $urandom;
            endcase
            r5 = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom);
            apply_in(r32, r5, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            @(negedge clk);
            checks++; if (bus32.valid_o !== m_valid[0]) $display("FAIL rnd_valid32 c=%0d: got %b want %b", c, bus32.valid_o, m_valid[0]); else passed++;
            checks++; if (bus32.oh_o !== exp_oh(0)) $display("FAIL rnd_oh32 c=%0d: got %h want %h", c, bus32.oh_o, exp_oh(0)); else passed++;
            checks++; if (bus32.idx_o !== 5'(exp_idx(0))) $display("FAIL rnd_idx32 c=%0d: got %0d want %0d", c, bus32.idx_o, exp_idx(0)); else passed++;
            checks++; if (bus32.gnt_o !== exp_gnt(0)) $display("FAIL rnd_gnt32 c=%0d: got %h want %h", c, bus32.gnt_o, exp_gnt(0)); else passed++;
            checks++; if (bus5.valid_o !== m_valid[1]) $display("FAIL rnd_valid5 c=%0d: got %b want %b", c, bus5.valid_o, m_valid[1]); else passed++;
            checks++; if ({27'b0, bus5.oh_o} !== exp_oh(1)) $display("FAIL rnd_oh5 c=%0d: got %h want %h", c, bus5.oh_o, exp_oh(1)); else passed++;
            checks++; if (bus5.idx_o !== 3'(exp_idx(1))) $display("FAIL rnd_idx5 c=%0d: got %0d want %0d", c, bus5.idx_o, exp_idx(1)); else passed++;
            checks++; if ({27'b0, bus5.gnt_o} !== exp_gnt(1)) $display("FAIL rnd_gnt5 c=%0d: got %h want %h", c, bus5.gnt_o, exp_gnt(1)); else passed++;
            advance();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    initial begin
        apply_in('0, '0, 1'b0, 1'b0);
        model_reset();
        #1;
        test_reset();
        test_round_robin();
        test_stall();
        test_non_pow2();
        test_lock();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
